// File: rtl/systolic_mm_array_if.sv
// systolic_mm_array_if: serial operand/result link between host and systolic engine
interface systolic_mm_array_if #(parameter int width_p = 8);
   logic               valid_i;
   logic               ready_o;
   logic [width_p-1:0] data_i;
   logic               valid_o;
   logic               yumi_i;
   logic [width_p-1:0] data_o;
   modport master (output valid_i, data_i, yumi_i, input ready_o, valid_o, data_o);
   modport slave  (input valid_i, data_i, yumi_i, output ready_o, valid_o, data_o);
endinterface

// File: rtl/systolic_mm_array.sv
// systolic_mm_array: output-stationary NxN systolic matrix multiplier with serial load and drain
module systolic_mm_array #(
   parameter int width_p        = 8,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 en_i,
   input  logic                 flush_i,
   systolic_mm_array_if.slave   link,
   output logic                 busy_o,
   output logic                 idle_o,
   output logic [7:0]           onehot_o
);
   localparam int n  = array_width_p < array_height_p ? array_width_p : array_height_p;
   localparam int nn = n * n;
   localparam int aw = 2 * width_p + $clog2(n);
   localparam int iw = $clog2(nn);
   localparam int cw = $clog2(nn + 3 * n);

   typedef enum logic [2:0] {idle_s, load_a_s, gap_s, load_b_s, compute_s, done_s, drain_s} state_t;

   state_t             state_q, state_d;
   logic [cw-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [iw-1:0]      idx;
   logic               last, beat, load_a, load_b, start, step;
   logic [width_p-1:0] a_mem [nn];
   logic [width_p-1:0] b_mem [nn];
   logic [width_p-1:0] a_q   [nn];
   logic [width_p-1:0] b_q   [nn];
   logic [width_p-1:0] a_in  [nn];
   logic [width_p-1:0] b_in  [nn];
   logic [aw-1:0]      acc_q [nn];

   // one counter serves as load index, compute cycle and output pointer
   assign idx     = cnt_q[iw-1:0];
   assign cnt_inc = cnt_q + 1'b1;
   assign last    = cnt_q == cw'(nn - 1);
   assign beat    = en_i & link.valid_i & link.ready_o;

   // state and counter register
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q <= idle_s;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   // next state, counter update and datapath strobes; nothing moves while en_i is low
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_a  = 1'b0;
      load_b  = 1'b0;
      start   = 1'b0;
      step    = 1'b0;
      if (en_i)
         case (state_q)
            idle_s:
               if (beat) begin
                  load_a  = 1'b1;
                  state_d = load_a_s;
                  cnt_d   = cw'(1);
               end
            load_a_s:
               if (beat) begin
                  load_a  = 1'b1;
                  state_d = last ? gap_s : load_a_s;
                  cnt_d   = last ? '0 : cnt_inc;
               end
            gap_s: state_d = load_b_s;
            load_b_s:
               if (beat) begin
                  load_b  = 1'b1;
                  start   = last;
                  state_d = last ? compute_s : load_b_s;
                  cnt_d   = last ? '0 : cnt_inc;
               end
            compute_s: begin
               step    = 1'b1;
               state_d = cnt_q == cw'(3 * n - 3) ? done_s : compute_s;
               cnt_d   = cnt_q == cw'(3 * n - 3) ? '0 : cnt_inc;
            end
            done_s:
               if (flush_i | link.yumi_i) begin
                  state_d = last ? idle_s : (flush_i ? drain_s : done_s);
                  cnt_d   = last ? '0 : cnt_inc;
               end
            drain_s: begin
               state_d = last ? idle_s : drain_s;
               cnt_d   = last ? '0 : cnt_inc;
            end
            default: state_d = idle_s;
         endcase
   end

   // skewed edge feeds: row r sees A[r][k-r], column c sees B[k-c][c]; inner PEs take neighbours
   always_comb begin
      for (int r = 0; r < n; r++) begin
         automatic int m = int'(cnt_q) - r;
         a_in[r*n] = (m >= 0 && m < n) ? a_mem[r*n + m] : '0;
         b_in[r]   = (m >= 0 && m < n) ? b_mem[m*n + r] : '0;
         for (int c = 1; c < n; c++) begin
            a_in[r*n + c] = a_q[r*n + c - 1];
            b_in[c*n + r] = b_q[(c-1)*n + r];
         end
      end
   end

   // operand storage written by the serial load
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i)
         for (int i = 0; i < nn; i++) begin
            a_mem[i] <= '0;
            b_mem[i] <= '0;
         end
      else begin
         if (load_a) a_mem[idx] <= link.data_i;
         if (load_b) b_mem[idx] <= link.data_i;
      end

   // PE grid: cleared on entry to compute, then MAC and forward a right / b down
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i)
         for (int i = 0; i < nn; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            acc_q[i] <= '0;
         end
      else
         for (int i = 0; i < nn; i++)
            if (start) begin
               a_q[i]   <= '0;
               b_q[i]   <= '0;
               acc_q[i] <= '0;
            end else if (step) begin
               a_q[i]   <= a_in[i];
               b_q[i]   <= b_in[i];
               acc_q[i] <= acc_q[i] + aw'(a_in[i]) * aw'(b_in[i]);
            end

   assign link.ready_o = state_q inside {idle_s, load_a_s, load_b_s, done_s};
   assign link.valid_o = state_q inside {done_s, drain_s};
   assign link.data_o  = link.valid_o ? acc_q[idx][width_p-1:0] : '0;
   assign busy_o       = state_q inside {compute_s, drain_s};
   assign idle_o       = state_q == idle_s;
   assign onehot_o     = 8'b1 << state_q;
endmodule

// File: tb/tb_systolic_mm_array.sv
// tb_systolic_mm_array: directed tests of load, compute, flush, pop, overflow, enable and abort
module tb_systolic_mm_array;
   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       en_i = 1'b1;
   logic       flush_i = 1'b0;
   logic       busy_o, idle_o;
   logic [7:0] onehot_o;
   int         total = 0;
   int         bad = 0;

   systolic_mm_array_if #(.width_p(8)) link();

   systolic_mm_array #(.width_p(8), .array_width_p(2), .array_height_p(2)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
      .link(link), .busy_o(busy_o), .idle_o(idle_o), .onehot_o(onehot_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic load_job(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 8; i++) begin
         link.valid_i = 1'b1;
         link.data_i  = i < 4 ? a[8*i +: 8] : b[8*(i-4) +: 8];
         tick;
         link.valid_i = 1'b0;
         if (i != 7) tick;
      end
   endtask

   task automatic wait_done;
      for (int k = 0; k < 20 && !link.valid_o; k++) tick;
      total++;
      if (link.valid_o !== 1'b1) begin
         bad++;
         $display("FAIL wait_done: valid_o=%b required 1", link.valid_o);
      end
   endtask

   task automatic test_reset;
      link.valid_i = 1'b1;
      link.data_i  = 8'd5;
      tick;
      link.valid_i = 1'b0;
      total++;
      if (onehot_o !== 8'h02) begin bad++; $display("FAIL pre_reset_onehot: got %h want 02", onehot_o); end
      #3 reset_i = 1'b1;
      #1;
      total++;
      if (idle_o !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle_o); end
      total++;
      if (link.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", link.ready_o); end
      total++;
      if (link.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", link.valid_o); end
      total++;
      if (link.data_o !== 8'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", link.data_o); end
      total++;
      if (onehot_o !== 8'h01) begin bad++; $display("FAIL reset_onehot: got %h want 01", onehot_o); end
      tick;
      reset_i = 1'b0;
      tick;
   endtask

   task automatic test_load;
      logic [31:0] v = {8'd4, 8'd3, 8'd2, 8'd1};
      for (int i = 0; i < 4; i++) begin
         link.valid_i = 1'b1;
         link.data_i  = v[8*i +: 8];
         tick;
         link.valid_i = 1'b0;
         if (i == 3) begin
            total++;
            if (link.ready_o !== 1'b0) begin bad++; $display("FAIL gap_ready: got %b want 0", link.ready_o); end
            total++;
            if (onehot_o !== 8'h04) begin bad++; $display("FAIL gap_onehot: got %h want 04", onehot_o); end
         end
         tick;
      end
      total++;
      if (link.ready_o !== 1'b1) begin bad++; $display("FAIL load_b_ready: got %b want 1", link.ready_o); end
      for (int i = 0; i < 4; i++) begin
         link.valid_i = 1'b1;
         link.data_i  = v[8*i +: 8];
         tick;
         link.valid_i = 1'b0;
         if (i != 3) tick;
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (busy_o !== 1'b1) begin bad++; $display("FAIL compute_busy[%0d]: got %b want 1", k, busy_o); end
         tick;
      end
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL done_busy: got %b want 0", busy_o); end
      total++;
      if (link.ready_o !== 1'b1) begin bad++; $display("FAIL done_ready: got %b want 1", link.ready_o); end
      total++;
      if (link.valid_o !== 1'b1) begin bad++; $display("FAIL done_valid: got %b want 1", link.valid_o); end
      total++;
      if (link.data_o !== 8'd7) begin bad++; $display("FAIL done_data: got %0d want 7", link.data_o); end
   endtask

   task automatic test_flush;
      logic [31:0] exp = {8'd22, 8'd15, 8'd10, 8'd7};
      flush_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (link.data_o !== exp[8*k +: 8]) begin bad++; $display("FAIL flush_data[%0d]: got %0d want %0d", k, link.data_o, exp[8*k +: 8]); end
         tick;
         flush_i = 1'b0;
      end
      total++;
      if (link.data_o !== 8'd0) begin bad++; $display("FAIL flush_end_data: got %0d want 0", link.data_o); end
      total++;
      if (link.valid_o !== 1'b0) begin bad++; $display("FAIL flush_end_valid: got %b want 0", link.valid_o); end
      total++;
      if (idle_o !== 1'b1) begin bad++; $display("FAIL flush_end_idle: got %b want 1", idle_o); end
   endtask

   task automatic test_pop;
      logic [31:0] exp = {8'd22, 8'd15, 8'd10, 8'd7};
      load_job({8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1});
      wait_done;
      for (int k = 0; k < 4; k++) begin
         int gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            total++;
            if (link.data_o !== exp[8*k +: 8]) begin bad++; $display("FAIL pop_hold[%0d]: got %0d want %0d", k, link.data_o, exp[8*k +: 8]); end
            tick;
         end
         link.yumi_i = 1'b1;
         total++;
         if (link.data_o !== exp[8*k +: 8]) begin bad++; $display("FAIL pop_data[%0d]: got %0d want %0d", k, link.data_o, exp[8*k +: 8]); end
         tick;
         link.yumi_i = 1'b0;
      end
      total++;
      if (idle_o !== 1'b1) begin bad++; $display("FAIL pop_end_idle: got %b want 1", idle_o); end
      total++;
      if (link.valid_o !== 1'b0) begin bad++; $display("FAIL pop_end_valid: got %b want 0", link.valid_o); end
   endtask

   task automatic test_overflow;
      load_job(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done;
      flush_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (link.data_o !== 8'd2) begin bad++; $display("FAIL overflow_data[%0d]: got %0d want 2", k, link.data_o); end
         tick;
         flush_i = 1'b0;
      end
      total++;
      if (idle_o !== 1'b1) begin bad++; $display("FAIL overflow_idle: got %b want 1", idle_o); end
   endtask

   task automatic test_enable;
      logic [31:0] exp = {8'd50, 8'd43, 8'd22, 8'd19};
      link.valid_i = 1'b1;
      link.data_i  = 8'd1;
      tick;
      link.data_i  = 8'd2;
      tick;
      en_i         = 1'b0;
      link.data_i  = 8'd99;
      for (int k = 0; k < 3; k++) begin
         tick;
         total++;
         if (onehot_o !== 8'h02) begin bad++; $display("FAIL en_hold_onehot[%0d]: got %h want 02", k, onehot_o); end
      end
      en_i        = 1'b1;
      link.data_i = 8'd3;
      tick;
      link.data_i = 8'd4;
      tick;
      link.valid_i = 1'b0;
      tick;
      for (int i = 5; i <= 8; i++) begin
         link.valid_i = 1'b1;
         link.data_i  = 8'(i);
         tick;
      end
      link.valid_i = 1'b0;
      wait_done;
      flush_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (link.data_o !== exp[8*k +: 8]) begin bad++; $display("FAIL en_result[%0d]: got %0d want %0d", k, link.data_o, exp[8*k +: 8]); end
         tick;
         flush_i = 1'b0;
      end
   endtask

   task automatic test_abort;
      logic [31:0] exp = {8'd10, 8'd7, 8'd8, 8'd5};
      load_job({8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1});
      tick;
      #2 reset_i = 1'b1;
      #1;
      total++;
      if (idle_o !== 1'b1) begin bad++; $display("FAIL abort_idle: got %b want 1", idle_o); end
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
      tick;
      reset_i = 1'b0;
      tick;
      load_job({8'd2, 8'd1, 8'd1, 8'd2}, {8'd4, 8'd3, 8'd2, 8'd1});
      wait_done;
      flush_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (link.data_o !== exp[8*k +: 8]) begin bad++; $display("FAIL abort_result[%0d]: got %0d want %0d", k, link.data_o, exp[8*k +: 8]); end
         tick;
         flush_i = 1'b0;
      end
   endtask

   initial begin
      link.valid_i = 1'b0;
      link.data_i  = '0;
      link.yumi_i  = 1'b0;
      tick;
      tick;
      reset_i = 1'b0;
      tick;
      test_reset;
      test_load;
      test_flush;
      test_pop;
      test_overflow;
      test_enable;
      test_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
